spi_input_conditioner: RTL

//  Front-end conditioner between the raw SPI pins (sclk, cs, mosi) and the SPI memory core.
//  Per channel: 2-flop synchronizer, counter-based glitch filter, one-cycle rise/fall pulses.
//  The SPI memory FSM consumes only conditioned levels and edge pulses, never raw pins.

---
 rtl/spi_cond_pkg.sv | 29 ++
 rtl/spi_input_conditioner_if.sv | 33 +++
 rtl/input_conditioner_ch.sv | 106 ++++++++++
 rtl/spi_input_conditioner.sv | 43 ++++
 4 files changed

// File: rtl/spi_cond_pkg.sv
// -----------------------------------------------------------------------------
// spi_cond_pkg
// Shared constants for the SPI input conditioner:
//   - channel indices (sclk, cs, mosi),
//   - default filter depth and per-channel reset levels,
//   - glitch counter width,
//   - a helper that sizes the stability counter.
// Optional feature macro used by the other files: SPI_COND_GLITCH_CNT_EN.
// -----------------------------------------------------------------------------
package spi_cond_pkg;

  localparam int NCH_DEF = 3;

  localparam int CH_SCLK = 0;
  localparam int CH_CS   = 1;
  localparam int CH_MOSI = 2;

  localparam int         WAIT_DEF      = 3;
  localparam logic [2:0] RESET_VAL_DEF = 3'b010;  // cs idles high

  localparam int GLITCH_W = 8;

  // Stability counter width. It only has to hold 0..WAIT-1, because it
  // clears on acceptance. The result is never narrower than one bit.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 2) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/spi_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// spi_input_conditioner_if
// This interface carries the signals between the raw SPI pins and the conditioned outputs.
//   pins_raw    raw asynchronous pins (bit0=sclk, bit1=cs, bit2=mosi)
//   cond        conditioned levels
//   rise/fall   one-cycle edge pulses on accepted level changes
//   glitch_cnt  8 bits per channel. It is present only when SPI_COND_GLITCH_CNT_EN is defined.
// Modports:
//   master  drives the pins and observes the outputs (pad side / bench)
//   slave   the conditioner itself
// -----------------------------------------------------------------------------
interface spi_input_conditioner_if
  import spi_cond_pkg::*;
#(
  parameter int NCH = NCH_DEF
);

  logic [NCH-1:0] pins_raw;
  logic [NCH-1:0] cond;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;

`ifdef SPI_COND_GLITCH_CNT_EN
  logic [GLITCH_W*NCH-1:0] glitch_cnt;

  modport master (output pins_raw, input cond, input rise, input fall, input glitch_cnt);
  modport slave  (input pins_raw, output cond, output rise, output fall, output glitch_cnt);
`else
  modport master (output pins_raw, input cond, input rise, input fall);
  modport slave  (input pins_raw, output cond, output rise, output fall);
`endif

endinterface

// File: rtl/input_conditioner_ch.sv
// -----------------------------------------------------------------------------
// input_conditioner_ch
// This module conditions a single pin. The pin passes through a 2-flop synchronizer.
// A level change is accepted only after the synchronized value has differed from the
// current level for WAIT consecutive cycles. On acceptance the module emits a
// registered one-cycle rise or fall pulse.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   pin_raw     asynchronous pin
//   cond        filtered level; it resets to RST_LVL
//   rise/fall   one-cycle pulses on accepted 0->1 / 1->0 changes
//   glitch_cnt  saturating count of rejected glitches. It exists only when
//               SPI_COND_GLITCH_CNT_EN is defined.
// -----------------------------------------------------------------------------
module input_conditioner_ch
  import spi_cond_pkg::*;
#(
  parameter int   WAIT    = WAIT_DEF,
  parameter logic RST_LVL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pin_raw,
  output logic                cond,
  output logic                rise,
  output logic                fall
`ifdef SPI_COND_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int             CNT_W    = cnt_width(WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             cond_reg, cond_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= RST_LVL;
      sync2_reg <= RST_LVL;
      cond_reg  <= RST_LVL;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= pin_raw;
      sync2_reg <= sync1_reg;
      cond_reg  <= cond_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The counter tracks how long sync2 has disagreed with cond. Any agreement
  // clears it, so a short excursion leaves no trace on cond or the pulses.
  always_comb begin
    cond_next = cond_reg;
    cnt_next  = '0;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (sync2_reg != cond_reg) begin
      if (cnt_reg == CNT_LAST) begin
        cond_next = sync2_reg;
        rise_next = sync2_reg;
        fall_next = ~sync2_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign cond = cond_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

`ifdef SPI_COND_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_reg, glitch_next;

  // A glitch is an excursion that ended before acceptance. That shows up as
  // agreement while the counter is still non-zero.
  always_comb begin
    glitch_next = glitch_reg;
    if ((sync2_reg == cond_reg) && (cnt_reg != '0) && (glitch_reg != '1)) begin
      glitch_next = glitch_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_reg <= '0;
    end else begin
      glitch_reg <= glitch_next;
    end
  end

  assign glitch_cnt = glitch_reg;
`endif

endmodule

// File: rtl/spi_input_conditioner.sv
// -----------------------------------------------------------------------------
// spi_input_conditioner
// This module is the front end between the raw SPI pins and the SPI memory core. It
// builds NCH independent conditioning channels (bit0=sclk, bit1=cs, bit2=mosi).
// Each channel has a synchronizer, a glitch filter and edge pulses.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    spi_input_conditioner_if.slave: pins_raw in; cond, rise, fall out.
//          glitch_cnt is also out when SPI_COND_GLITCH_CNT_EN is defined.
// Note for consumers: the sclk period must exceed 2*(WAIT+1) clk cycles.
// -----------------------------------------------------------------------------
module spi_input_conditioner
  import spi_cond_pkg::*;
#(
  parameter int             NCH       = NCH_DEF,
  parameter int             WAIT      = WAIT_DEF,
  parameter logic [NCH-1:0] RESET_VAL = NCH'(RESET_VAL_DEF)
) (
  input logic                    clk,
  input logic                    reset,
  spi_input_conditioner_if.slave bus
);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    input_conditioner_ch #(
      .WAIT    (WAIT),
      .RST_LVL (RESET_VAL[gi])
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .pin_raw    (bus.pins_raw[gi]),
      .cond       (bus.cond[gi]),
      .rise       (bus.rise[gi]),
      .fall       (bus.fall[gi])
`ifdef SPI_COND_GLITCH_CNT_EN
      ,
      .glitch_cnt (bus.glitch_cnt[GLITCH_W*gi +: GLITCH_W])
`endif
    );
  end

endmodule
